// File: rtl/cpu_pkg.sv
// Shared core definitions: cache operation codes and memory-port owner IDs
// used by the unified memory port arbiter and its owner FIFO.
package cpu_pkg;

   localparam logic CACHE_READ  = 1'b0;
   localparam logic CACHE_WRITE = 1'b1;

   typedef enum logic {
      OWN_I = 1'b0,
      OWN_D = 1'b1
   } owner_t;

endpackage

// File: rtl/owner_fifo.sv
// In-order FIFO of owner IDs, one entry per outstanding cache read.
// Full/empty come from the registered count, so a push into a full FIFO is refused even with a pop.
module owner_fifo
   import cpu_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic   clk,
   input  logic   reset,
   input  logic   push,
   input  logic   pop,
   input  owner_t din,
   output owner_t head,
   output logic   full,
   output logic   empty
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic [CW-1:0] count;
   owner_t        slots [DEPTH];
   logic          do_push;
   logic          do_pop;

   assign full    = (count == CW'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;
   assign head    = slots[rd_ptr];

   // NOTE: non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   // NOTE: storage is not reset; the count alone decides which slots are valid.
   always_ff @(posedge clk) begin
      if (do_push) slots[wr_ptr] <= din;
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one cache port between instruction fetch and data requesters: round-robin grant held
// until accepted, with an in-order owner FIFO steering each read response back to its requester.
module mem_port_arbiter
   import cpu_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int AW    = 32,
   parameter int DW    = 32
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          i_valid_in,
   input  logic [AW-1:0] i_addr_in,
   output logic          i_ready_out,
   input  logic          d_valid_in,
   input  logic          d_op_in,
   input  logic [AW-1:0] d_addr_in,
   input  logic [DW-1:0] d_wdata_in,
   output logic          d_ready_out,
   output logic          mem_valid_in,
   output logic [AW-1:0] mem_addr,
   output logic          mem_op,
   output logic [DW-1:0] mem_wdata,
   input  logic          mem_ready_in,
   input  logic          mem_valid_out,
   input  logic [DW-1:0] mem_data,
   output logic          mem_ready_out,
   output logic          i_rsp_valid,
   output logic [DW-1:0] i_rsp_data,
   input  logic          i_rsp_ready,
   output logic          d_rsp_valid,
   output logic [DW-1:0] d_rsp_data,
   input  logic          d_rsp_ready
);

   owner_t gnt;
   owner_t last_grant;
   owner_t lock_owner;
   owner_t head;
   logic   lock;
   logic   gnt_any;
   logic   i_elig;
   logic   d_elig;
   logic   accept;
   logic   push;
   logic   pop;
   logic   full;
   logic   empty;
   logic   head_ready;

   // Writes bypass the FIFO, so only reads are held back by a full FIFO.
   assign i_elig = i_valid_in & ~full;
   assign d_elig = d_valid_in & ((d_op_in == CACHE_WRITE) | ~full);

   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      gnt     = OWN_I;
      gnt_any = 1'b0;
      if (lock) begin
         gnt     = lock_owner;
         gnt_any = (lock_owner == OWN_D) ? d_elig : i_elig;
      end else if (i_elig && d_elig) begin
         gnt     = (last_grant == OWN_I) ? OWN_D : OWN_I;
         gnt_any = 1'b1;
      end else if (d_elig) begin
         gnt     = OWN_D;
         gnt_any = 1'b1;
      end else if (i_elig) begin
         gnt     = OWN_I;
         gnt_any = 1'b1;
      end
   end

   assign mem_valid_in = gnt_any & ~reset;
   assign accept       = mem_valid_in & mem_ready_in;
   assign i_ready_out  = accept & (gnt == OWN_I);
   assign d_ready_out  = accept & (gnt == OWN_D);

   assign mem_addr  = (gnt == OWN_D) ? d_addr_in  : i_addr_in;
   assign mem_op    = (gnt == OWN_D) ? d_op_in    : CACHE_READ;
   assign mem_wdata = (gnt == OWN_D) ? d_wdata_in : '0;

   assign push = accept & (mem_op == CACHE_READ);

   // A response with no outstanding tag is never acknowledged and leaves the FIFO untouched.
   assign head_ready    = (head == OWN_D) ? d_rsp_ready : i_rsp_ready;
   assign mem_ready_out = ~reset & ~empty & head_ready;
   assign i_rsp_valid   = ~reset & mem_valid_out & ~empty & (head == OWN_I);
   assign d_rsp_valid   = ~reset & mem_valid_out & ~empty & (head == OWN_D);
   assign i_rsp_data    = mem_data;
   assign d_rsp_data    = mem_data;
   assign pop           = mem_valid_out & mem_ready_out;

   always_ff @(posedge clk) begin
      if (reset) begin
         lock       <= 1'b0;
         lock_owner <= OWN_I;
         last_grant <= OWN_I;
      end else if (accept) begin
         lock       <= 1'b0;
         last_grant <= gnt;
      end else if (mem_valid_in) begin
         lock       <= 1'b1;
         lock_owner <= gnt;
      end
   end

   owner_fifo #(
      .DEPTH(DEPTH)
   ) u_owner_fifo (
      .clk  (clk),
      .reset(reset),
      .push (push),
      .pop  (pop),
      .din  (gnt),
      .head (head),
      .full (full),
      .empty(empty)
   );

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Arbiter that shares one `cache` instance between the instruction-fetch requester (stage 1) and the data requester (stage 3b), so the core can run on a single unified memory port. It grants requests round-robin and holds each grant until the cache accepts it. It records the owner of every outstanding read in an in-order tag FIFO and routes each cache response back to its owner. It sits between the pipeline stages and the cache, and presents the cache's own ready/valid port shape on both sides.

## Interface
- `DEPTH`, default 4: maximum outstanding reads; power of two, ≥2.
- `AW`, default 32: address width.
- `DW`, default 32: data width.

- `clk` in 1: single clock.
- `reset` in 1: synchronous, active-high.
- `i_valid_in` in 1: fetch request valid; always `CACHE_READ`.
- `i_addr_in` in AW: fetch address.
- `i_ready_out` out 1: fetch request accepted this cycle.
- `d_valid_in` in 1: data request valid.
- `d_op_in` in 1: `CACHE_READ` / `CACHE_WRITE`.
- `d_addr_in` in AW: data address.
- `d_wdata_in` in DW: store data.
- `d_ready_out` out 1: data request accepted this cycle.
- `mem_valid_in` out 1: request to cache valid.
- `mem_addr`, `mem_op`, `mem_wdata`: muxed request fields to cache.
- `mem_ready_in` in 1: cache can accept a request.
- `mem_valid_out` in 1: cache response valid.
- `mem_data` in DW: cache response data.
- `mem_ready_out` out 1: arbiter accepts the response.
- `i_rsp_valid` out 1: fetch response valid.
- `i_rsp_data` out DW: fetch response data.
- `i_rsp_ready` in 1: fetch stage can take the response.
- `d_rsp_valid` out 1: data response valid.
- `d_rsp_data` out DW: data response data.
- `d_rsp_ready` in 1: data stage can take the response.

## Operation
- Eligibility:
  - Reads are eligible only when the FIFO is not full.
  - Writes are always eligible and are never pushed; the cache returns no write response.
- Arbitration:
  - One eligible requester: grant it.
  - Both eligible: grant the one opposite `last_grant`.
  - `last_grant` updates only on an accepted request.
- Grant lock (`lock`, `lock_owner`):
  - Set when `mem_valid_in & !mem_ready_in`.
  - While locked, the grant stays on `lock_owner` regardless of the other requester.
  - Cleared on acceptance.
  - Requesters must hold valid and fields stable until accepted.
- Acceptance: `mem_valid_in & mem_ready_in`. `i_ready_out` / `d_ready_out` assert only for the granted requester in that cycle.
- Owner FIFO: an accepted read pushes its owner ID (`OWN_I`=0, `OWN_D`=1).
- Response routing: the head owner selects the destination.
  - `x_rsp_valid = mem_valid_out & !empty & head==x`.
  - `mem_ready_out = !empty & x_rsp_ready` of the head owner.
  - Pop when `mem_valid_out & mem_ready_out`.
- `mem_valid_out` while the FIFO is empty is a protocol error: `mem_ready_out` = 0, the response is dropped, and the FIFO state is unchanged.
- Full FIFO: a push is blocked even if a pop occurs in the same cycle (full is computed from the registered count). Simultaneous push+pop when not full leaves the count unchanged.
- Reset:
  - Synchronous: FIFO is emptied, `lock` = 0, `last_grant` = `OWN_I` (data wins the first conflict).
  - Applies mid-transaction too: outstanding tags are discarded and in-flight responses are unrouted; the cache is reset concurrently.

## Timing
- Request path is combinational, 0 cycles: valid → `mem_valid_in` → `x_ready_out` in the same cycle.
- Response path is combinational, 0 cycles: `mem_valid_out` → `x_rsp_valid`, with no buffering.
- Throughput: 1 request/cycle; back-to-back grants alternate under contention.
- Push/pop, `lock` and `last_grant` update on `posedge clk`.
- While `reset` is high, all valid/ready outputs are forced to 0. On the first cycle after reset, outputs follow the inputs with state at its reset values.
- Count width is `$clog2(DEPTH)+1`. Pointers are `$clog2(DEPTH)` bits and wrap naturally.

## Structure
- Shared package `cpu_pkg` holds:
  - `CACHE_READ` / `CACHE_WRITE`;
  - `OWN_I` / `OWN_D`;
  - the owner typedef.
- Sub-module `owner_fifo` (DEPTH×1-bit synchronous FIFO) exposes `push`, `pop`, `din`, `head`, `full`, `empty`.
- Top level holds the arbitration, lock and routing logic.

## Test plan
1. Solo fetch: `i_valid_in`=1, addr 0x10, `mem_ready_in`=1 → `i_ready_out`=1 the same cycle, count=1. Response 0xDEAD → `i_rsp_valid`=1, data 0xDEAD, count=0.
2. Contention after reset: both valid, both reads → d granted first, then i, then d. Responses return in order d, i, d to the correct ports.
3. Lock: d presented with `mem_ready_in`=0 for 3 cycles while i asserts → `mem_addr` stays the d address; d is accepted in cycle 4; i is granted in cycle 5.
4. Full: 4 fetch reads accepted with no responses → 5th `i_ready_out`=0; a d write is still granted; one pop then allows the fetch on the next cycle.
5. Backpressure: head=D and `d_rsp_ready`=0 → `mem_ready_out`=0, FIFO is held, and no data appears on the i port.
6. Reset mid-flight: count=3, then `reset` for 1 cycle → empty, `lock`=0, all outputs 0 during reset, and normal grant resumes the next cycle.
